// File: rtl/uart_cmd_frame_tx.sv
// Host-side UART command transmitter: serializes one accepted WR/RD/ALU request as 2-4 UART frames.
// Define UART_CMD_TX_IFG_EN to insert IFG_BITS idle bit-times between the frames of one packet.
module uart_cmd_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int IFG_BITS   = 2
) (
  input  logic                  UART_CLK,
  input  logic                  rst_n,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_TYPE,
  input  logic [DATA_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_OPA,
  input  logic [DATA_WIDTH-1:0] CMD_OPB,
  input  logic [DATA_WIDTH-1:0] CMD_FUN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  CMD_DONE
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (IFG_BITS > 1) ? $clog2(IFG_BITS) : 1;
  localparam int BIT_W = (IDX_W > GAP_W) ? IDX_W : GAP_W;

  localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
    logic p;
    if (odd) p = ~^data;
    else     p = ^data;
    return p;
  endfunction

  state_t                         state_q, state_d;
  logic [PRESCALE_W-1:0]          cnt_q, cnt_d;
  logic [PRESCALE_W-1:0]          presc_q, presc_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic [1:0]                     idx_q, idx_d;
  logic [1:0]                     last_q, last_d;
  logic [3:0][DATA_WIDTH-1:0]     frames_q, frames_d;
  logic                           par_en_q, par_en_d;
  logic                           par_typ_q, par_typ_d;
  logic                           tx_q, tx_d;
  logic                           busy_q, busy_d;
  logic                           ready_q, ready_d;
  logic                           frame_done_q, frame_done_d;
  logic                           cmd_done_q, cmd_done_d;

  logic [DATA_WIDTH-1:0]          cur_frame_s;
  logic [PRESCALE_W-1:0]          presc_last_s;
  logic [PRESCALE_W-1:0]          presc_pre_s;
  logic [BIT_W-1:0]               bit_nxt_s;
  logic                           bit_end_s;
  logic                           stop_pre_s;
  logic                           last_frame_s;

  assign cur_frame_s  = frames_q[idx_q];
  assign presc_last_s = presc_q - PRESCALE_W'(1);
  assign presc_pre_s  = presc_q - PRESCALE_W'(2);
  assign bit_nxt_s    = bit_q + BIT_W'(1);
  assign bit_end_s    = (cnt_q == presc_last_s);
  // Captured prescale is never below 2, so "one cycle before the last" always exists.
  assign stop_pre_s   = (cnt_q == presc_pre_s);
  assign last_frame_s = (idx_q == last_q);

  // Next-state and next-output logic for the packet sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    last_d       = last_q;
    frames_d     = frames_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    cmd_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (CMD_VALID && ready_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_d     = '0;
          idx_d     = 2'd0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          if (Prescale < PRESCALE_W'(2)) presc_d = PRESCALE_W'(8);
          else                           presc_d = Prescale;
          frames_d = '0;
          case (CMD_TYPE)
            2'b00: begin
              frames_d[0] = HDR_WR;
              frames_d[1] = CMD_ADDR;
              frames_d[2] = CMD_OPA;
              last_d      = 2'd2;
            end
            2'b01: begin
              frames_d[0] = HDR_RD;
              frames_d[1] = CMD_ADDR;
              last_d      = 2'd1;
            end
            2'b10: begin
              frames_d[0] = HDR_ALU;
              frames_d[1] = CMD_OPA;
              frames_d[2] = CMD_OPB;
              frames_d[3] = CMD_FUN;
              last_d      = 2'd3;
            end
            2'b11: begin
              frames_d[0] = HDR_NOP;
              frames_d[1] = CMD_FUN;
              last_d      = 2'd1;
            end
            default: begin
              frames_d[0] = HDR_RD;
              frames_d[1] = CMD_ADDR;
              last_d      = 2'd1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = cur_frame_s[0];
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = parity_bit(cur_frame_s, par_typ_q);
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt_s;
            tx_d  = cur_frame_s[bit_nxt_s[IDX_W-1:0]];
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      S_STOP: begin
        frame_done_d = stop_pre_s;
        cmd_done_d   = stop_pre_s && last_frame_s;
        if (bit_end_s) begin
          cnt_d = '0;
          if (last_frame_s) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            // Index only advances below last_q, so it can never run into another type's frames.
            idx_d = idx_q + 2'd1;
`ifdef UART_CMD_TX_IFG_EN
            state_d = S_GAP;
            bit_d   = '0;
            tx_d    = 1'b1;
`else
            state_d = S_START;
            tx_d    = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
`ifdef UART_CMD_TX_IFG_EN
      S_GAP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(IFG_BITS - 1)) begin
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            bit_d = bit_nxt_s;
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered-output flops; reset drops the line high immediately.
  always_ff @(posedge UART_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      presc_q      <= PRESCALE_W'(8);
      bit_q        <= '0;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      frames_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      cmd_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      frames_q     <= frames_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      cmd_done_q   <= cmd_done_d;
    end
  end

  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;
  assign CMD_READY  = ready_q;
  assign FRAME_DONE = frame_done_q;
  assign CMD_DONE   = cmd_done_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Self-checking bench for uart_cmd_frame_tx: a per-cycle line/pulse reference built from packet rules.
module tb_uart_cmd_frame_tx;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] fun;
    logic       par_en;
    logic       par_typ;
    logic [5:0] presc;
  } req_t;

  logic       clk;
  logic       rst_n;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_TYPE;
  logic [7:0] CMD_ADDR;
  logic [7:0] CMD_OPA;
  logic [7:0] CMD_OPB;
  logic [7:0] CMD_FUN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       BUSY;
  logic       FRAME_DONE;
  logic       CMD_DONE;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle {tx, frame_done, cmd_done}, index 0 = first cycle after accept.
  logic [2:0] exp_q[$];

  uart_cmd_frame_tx dut (
    .UART_CLK  (clk),
    .rst_n     (rst_n),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_TYPE  (CMD_TYPE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_OPA   (CMD_OPA),
    .CMD_OPB   (CMD_OPB),
    .CMD_FUN   (CMD_FUN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE),
    .CMD_DONE  (CMD_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic [1:0] typ, input logic [7:0] addr, input logic [7:0] opa,
                                  input logic [7:0] opb, input logic [7:0] fun, input logic pe,
                                  input logic pt, input logic [5:0] ps);
    req_t r;
    r.typ = typ; r.addr = addr; r.opa = opa; r.opb = opb; r.fun = fun;
    r.par_en = pe; r.par_typ = pt; r.presc = ps;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [5:0] ps;
    case ($urandom_range(0, 5))
      0:       ps = 6'd0;
      1:       ps = 6'd1;
      2:       ps = 6'd32;
      default: ps = 6'($urandom_range(2, 20));
    endcase
    r = mk_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ps);
    return r;
  endfunction

  // Reference: frame list per command type, then each frame as start/data(LSB first)/parity/stop.
  function automatic void build_model(input req_t r);
    logic [7:0] fr[$];
    logic       lvl[$];
    int         p;
    logic       stop_end;
    logic       par;
    exp_q.delete();
    fr.delete();
    p = (r.presc < 6'd2) ? 8 : int'(r.presc);
    case (r.typ)
      2'd0: begin fr.push_back(8'hAA); fr.push_back(r.addr); fr.push_back(r.opa); end
      2'd1: begin fr.push_back(8'hBB); fr.push_back(r.addr); end
      2'd2: begin fr.push_back(8'hCC); fr.push_back(r.opa); fr.push_back(r.opb); fr.push_back(r.fun); end
      default: begin fr.push_back(8'hDD); fr.push_back(r.fun); end
    endcase
    for (int f = 0; f < fr.size(); f++) begin
      lvl.delete();
      lvl.push_back(1'b0);
      for (int b = 0; b < 8; b++) lvl.push_back(fr[f][b]);
      if (r.par_en) begin
        par = r.par_typ ? ~^fr[f] : ^fr[f];
        lvl.push_back(par);
      end
      lvl.push_back(1'b1);
      for (int k = 0; k < lvl.size(); k++) begin
        for (int c = 0; c < p; c++) begin
          stop_end = (k == lvl.size() - 1) && (c == p - 1);
          exp_q.push_back({lvl[k], stop_end, stop_end && (f == fr.size() - 1)});
        end
      end
`ifdef UART_CMD_TX_IFG_EN
      if (f != fr.size() - 1) begin
        for (int g = 0; g < 2 * p; g++) exp_q.push_back(3'b100);
      end
`endif
    end
  endfunction

  task automatic drive_req(input req_t r);
    CMD_TYPE = r.typ; CMD_ADDR = r.addr; CMD_OPA = r.opa; CMD_OPB = r.opb; CMD_FUN = r.fun;
    PAR_EN = r.par_en; PAR_TYP = r.par_typ; Prescale = r.presc;
  endtask

  task automatic scramble_inputs();
    CMD_TYPE = 2'($urandom); CMD_ADDR = 8'($urandom); CMD_OPA = 8'($urandom);
    CMD_OPB = 8'($urandom); CMD_FUN = 8'($urandom); PAR_EN = 1'($urandom);
    PAR_TYP = 1'($urandom); Prescale = 6'($urandom);
  endtask

  // Called just after the accepting edge; checks the whole packet and the following idle cycle.
  task automatic expect_packet(input req_t r, input bit scramble, output int done_at);
    build_model(r);
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (scramble) scramble_inputs();
      check_eq("tx", TX_OUT, exp_q[i][2]);
      check_eq("frame_done", FRAME_DONE, exp_q[i][1]);
      check_eq("cmd_done", CMD_DONE, exp_q[i][0]);
      check_eq("busy", BUSY, 1'b1);
      check_eq("ready_low", CMD_READY, 1'b0);
      if (CMD_DONE === 1'b1 && done_at < 0) done_at = i + 1;
    end
    @(negedge clk);
    check_eq("done_cycle", done_at, exp_q.size());
    check_eq("idle_tx", TX_OUT, 1'b1);
    check_eq("idle_busy", BUSY, 1'b0);
    check_eq("idle_ready", CMD_READY, 1'b1);
  endtask

  task automatic send(input req_t r, input bit scramble, output int done_at);
    @(negedge clk);
    drive_req(r);
    CMD_VALID = 1'b1;
    check_eq("ready_pre", CMD_READY, 1'b1);
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    expect_packet(r, scramble, done_at);
  endtask

  initial begin
    req_t r, r2;
    int   done_at;

    rst_n = 1'b0;
    CMD_VALID = 1'b0;
    drive_req(mk_req(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 6'd8));

    repeat (3) @(negedge clk);
    check_eq("rst_tx", TX_OUT, 1'b1);
    check_eq("rst_busy", BUSY, 1'b0);
    check_eq("rst_ready", CMD_READY, 1'b1);
    check_eq("rst_fd", FRAME_DONE, 1'b0);
    check_eq("rst_cd", CMD_DONE, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("idle_line", {TX_OUT, CMD_READY, BUSY, FRAME_DONE, CMD_DONE}, 5'b11000);
    end

    // WR, odd parity: AA/05/3C, 3 x 11 x 8 = 264 cycles.
    r = mk_req(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b1, 6'd8);
    send(r, 1'b0, done_at);
    check_eq("wr_len", done_at, 264);

    // RD, even parity: BB/07.
    r = mk_req(2'd1, 8'h07, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 6'd8);
    send(r, 1'b0, done_at);
    check_eq("rd_len", done_at, 176);

    // ALU_NOP without parity, inputs (incl. Prescale) disturbed mid-packet.
    r = mk_req(2'd3, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 6'd16);
    send(r, 1'b1, done_at);
    check_eq("nop_len", done_at, 320);

    // Two ALU_OP packets with CMD_VALID held high throughout.
    r  = mk_req(2'd2, 8'h00, 8'h12, 8'h34, 8'h01, 1'b1, 1'b0, 6'd8);
    r2 = mk_req(2'd2, 8'h00, 8'hF0, 8'h0F, 8'h03, 1'b0, 1'b1, 6'd4);
    @(negedge clk);
    drive_req(r);
    CMD_VALID = 1'b1;
    @(posedge clk);
    #1 drive_req(r2);
    expect_packet(r, 1'b0, done_at);
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    expect_packet(r2, 1'b0, done_at);

    // ALU_OP aborted by reset during the start bit of the OPB frame.
    r = mk_req(2'd2, 8'h00, 8'hA5, 8'h5A, 8'h07, 1'b1, 1'b0, 6'd8);
    build_model(r);
    @(negedge clk);
    drive_req(r);
    CMD_VALID = 1'b1;
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    for (int i = 0; i < 2 * 88 + 3; i++) begin
      @(negedge clk);
      check_eq("pre_rst_tx", TX_OUT, exp_q[i][2]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_tx", TX_OUT, 1'b1);
    check_eq("async_busy", BUSY, 1'b0);
    check_eq("async_ready", CMD_READY, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_eq("post_rst", {TX_OUT, BUSY, CMD_DONE}, 3'b100);
    end
    r = mk_req(2'd0, 8'h21, 8'h9E, 8'h00, 8'h00, 1'b1, 1'b1, 6'd8);
    send(r, 1'b0, done_at);

    // Randomized packets, half with disturbed inputs mid-packet.
    for (int n = 0; n < 12; n++) begin
      r = rand_req();
      send(r, 1'((n % 2) != 0), done_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_frame_tx.md
Name: uart_cmd_frame_tx

Overview:
Host-side UART command transmitter. It drives the system's RX_IN with complete command packets: write (0xAA), read (0xBB), ALU with operands (0xCC) and ALU without operands (0xDD). Each accepted request is serialized as 2-4 back-to-back UART frames. Parity and prescale are runtime-configurable. It is used as the link initiator in system-level benches and as a reusable host/bridge front end.

Parameters:
DATA_WIDTH, 8, width of each frame payload.
PRESCALE_W, 6, width of the Prescale input.
IFG_BITS, 2, idle bit-times between frames of one packet (used only with the optional feature).

Ports:
UART_CLK  in  1  oversampled UART clock; one bit-time = Prescale cycles.
rst_n  in  1  asynchronous active-low reset.
CMD_VALID  in  1  request valid.
CMD_READY  out  1  high only in IDLE.
CMD_TYPE  in  2  00=WR(0xAA), 01=RD(0xBB), 10=ALU_OP(0xCC), 11=ALU_NOP(0xDD).
CMD_ADDR  in  DATA_WIDTH  register address (WR, RD).
CMD_OPA  in  DATA_WIDTH  write data (WR) or operand A (ALU_OP).
CMD_OPB  in  DATA_WIDTH  operand B (ALU_OP).
CMD_FUN  in  DATA_WIDTH  ALU function (ALU_OP, ALU_NOP).
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even, 1 = odd.
Prescale  in  PRESCALE_W  oversampling ratio (8/16/32 nominal).
TX_OUT  out  1  serial line, idle high.
BUSY  out  1  packet in progress.
FRAME_DONE  out  1  one-cycle pulse at the end of each stop bit.
CMD_DONE  out  1  one-cycle pulse at the end of the last frame's stop bit.

Behaviour:
- Reset (async, rst_n=0):
  - TX_OUT=1, BUSY=0, CMD_READY=1, FRAME_DONE=0, CMD_DONE=0.
  - All counters and the FSM go to 0/IDLE immediately.
  - Reset mid-frame aborts the packet; the line returns high the same instant.
- Accept: CMD_VALID&&CMD_READY on a rising edge.
  - Captures CMD_TYPE, all payload fields, PAR_EN, PAR_TYP and Prescale.
  - Input changes during the packet have no effect.
  - Prescale<2 is captured as 8.
- Frame sequence per type:
  - WR: AA, ADDR, OPA.
  - RD: BB, ADDR.
  - ALU_OP: CC, OPA, OPB, FUN.
  - ALU_NOP: DD, FUN.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> START of the next frame, or IDLE after the last frame.
- Latency: TX_OUT goes low on the cycle after accept (TX_OUT is registered).
- Bit timing:
  - Each state holds TX_OUT for exactly Prescale cycles, counted by a prescale counter 0..Prescale-1.
  - The bit counter indexes 0..DATA_WIDTH-1, LSB first.
  - Frame length = (10 + PAR_EN) * Prescale cycles.
- Line levels:
  - START=0, STOP=1.
  - PARITY = ^payload when even, ~^payload when odd.
- Frames are back-to-back: the next start bit follows the stop bit with no gap.
- Pulses:
  - FRAME_DONE pulses on the last cycle of every stop bit.
  - CMD_DONE coincides with FRAME_DONE of the final frame.
- IDLE transitions:
  - BUSY falls and CMD_READY rises the cycle after CMD_DONE.
  - A request presented then is accepted immediately; minimum inter-packet line idle is 1 cycle.
- Frame index counter is 2 bits; it saturates at the packet's frame count and never wraps into another type's frames.

Optional Feature:
Macro UART_CMD_TX_IFG_EN.
- Defined: after every non-final stop bit, TX_OUT holds 1 for IFG_BITS*Prescale extra cycles (state GAP) before the next start bit. FRAME_DONE timing is unchanged; CMD_DONE timing is unchanged relative to the final stop bit.
- Undefined: no GAP state; frames are strictly back-to-back.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> TX_OUT=1, CMD_READY=1, BUSY=0, no pulses for 100 cycles.
- WR, Prescale=8, PAR_EN=1, PAR_TYP=1, ADDR=0x05, OPA=0x3C -> frames AA(par 1), 05(par 1), 3C(par 1); 264 cycles; 3 FRAME_DONE pulses; CMD_DONE at cycle 264.
- RD, Prescale=8, PAR_EN=1, PAR_TYP=0, ADDR=0x07 -> AA-free stream BB(par 0), 07(par 1); a receiver model decodes both with no parity/frame error.
- ALU_NOP, Prescale=16, PAR_EN=0, FUN=0x02 -> DD, 02, each 160 cycles with no parity bit; change Prescale to 8 mid-packet -> timing unchanged.
- ALU_OP with CMD_VALID held high for two packets -> second start bit exactly 2 cycles after the first CMD_DONE.
- ALU_OP reset asserted mid-OPB frame -> TX_OUT=1 asynchronously; BUSY=0; no CMD_DONE; next WR request transmits cleanly.
